// File: rtl/serialiser.sv
// Byte-to-bit serialiser for the TX path, with optional odd parity after full bytes.
// Parity insertion is compiled in when SERIALISER_PARITY_EN is defined.
module serialiser #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic [2:0] in_bits,
    output logic       in_ready,
    output logic       out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

`ifdef SERIALISER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       last_q, last_d;
    logic [2:0] bits_q, bits_d;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;

    logic [2:0] last_idx;
    logic       data_end;
    logic       bit_xfer;
    logic       byte_xfer;
    logic       byte_end;
    logic       sel_bit;

    assign last_idx = (last_q && bits_q != 3'd0) ? bits_q - 3'd1 : 3'd7;
    assign data_end = (state_q == S_DATA) && (cnt_q == last_idx);
    assign bit_xfer = out_valid && out_ready;
    assign sel_bit  = LSB_FIRST ? byte_q[cnt_q] : byte_q[3'd7 - cnt_q];

`ifdef SERIALISER_PARITY_EN
    logic partial;
    assign partial  = last_q && (bits_q != 3'd0);
    // A full byte ends on its parity bit, a partial one on its last data bit.
    assign byte_end = bit_xfer &&
                      ((data_end && partial) || state_q == S_PARITY);
`else
    assign byte_end = bit_xfer && data_end;
`endif

    // Accept the next byte in the same cycle the current one finishes.
    assign in_ready  = !rst && (state_q == S_IDLE || (byte_end && !last_q));
    assign byte_xfer = in_valid && in_ready;
    assign busy      = busy_q;

    always_comb begin
        out_valid = 1'b0;
        out_data  = 1'b0;
        out_last  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                out_valid = 1'b0;
            end
            S_DATA: begin
                out_valid = 1'b1;
                out_data  = sel_bit;
`ifdef SERIALISER_PARITY_EN
                out_last  = data_end && partial;
`else
                out_last  = data_end && last_q;
`endif
            end
`ifdef SERIALISER_PARITY_EN
            S_PARITY: begin
                out_valid = 1'b1;
                out_data  = ~^byte_q;
                out_last  = last_q;
            end
`endif
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        last_d  = last_q;
        bits_d  = bits_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;

        if (bit_xfer && state_q == S_DATA && !data_end) begin
            cnt_d = cnt_q + 3'd1;
        end
`ifdef SERIALISER_PARITY_EN
        if (bit_xfer && data_end && !partial) begin
            state_d = S_PARITY;
        end
`endif
        if (byte_end) begin
            state_d = S_IDLE;
            if (last_q) begin
                busy_d = 1'b0;
            end
        end
        if (byte_xfer) begin
            state_d = S_DATA;
            byte_d  = in_data;
            last_d  = in_last;
            bits_d  = in_bits;
            cnt_d   = 3'd0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            byte_q  <= 8'd0;
            last_q  <= 1'b0;
            bits_q  <= 3'd0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

endmodule
